// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle for mc_ctrl_fsm: IR fields and ALU flags in, strobes and selects out.
// mem_ready exists only when MC_MEMWAIT_EN is defined.
interface mc_ctrl_fsm_if #(
  parameter int unsigned FLAG_W     = 4,
  parameter int unsigned ALU_CTRL_W = 4
);
  logic                  run;
  logic [1:0]            op;
  logic [2:0]            funct;
  logic [FLAG_W-1:0]     flags;
`ifdef MC_MEMWAIT_EN
  logic                  mem_ready;
`endif
  logic                  pc_write;
  logic                  ir_write;
  logic                  reg_write;
  logic                  mem_write;
  logic [1:0]            adr_src;
  logic [2:0]            reg_src;
  logic                  imm_src;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            result_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  halted;
  logic [3:0]            state;

`ifdef MC_MEMWAIT_EN
  modport master (
    input  run, op, funct, flags, mem_ready,
    output pc_write, ir_write, reg_write, mem_write, adr_src, reg_src, imm_src,
           alu_src_a, alu_src_b, result_src, alu_control, halted, state
  );
  modport slave (
    output run, op, funct, flags, mem_ready,
    input  pc_write, ir_write, reg_write, mem_write, adr_src, reg_src, imm_src,
           alu_src_a, alu_src_b, result_src, alu_control, halted, state
  );
`else
  modport master (
    input  run, op, funct, flags,
    output pc_write, ir_write, reg_write, mem_write, adr_src, reg_src, imm_src,
           alu_src_a, alu_src_b, result_src, alu_control, halted, state
  );
  modport slave (
    output run, op, funct, flags,
    input  pc_write, ir_write, reg_write, mem_write, adr_src, reg_src, imm_src,
           alu_src_a, alu_src_b, result_src, alu_control, halted, state
  );
`endif
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle controller FSM: sequences fetch/decode/execute/memory/writeback, with pause, sticky HALT
// and a flag register for conditional branches. Define MC_MEMWAIT_EN to add the mem_ready handshake.
module mc_ctrl_fsm #(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter int unsigned FLAG_W      = 4,
  parameter int unsigned Z_IDX       = 2,
  parameter int unsigned C_IDX       = 1,
  parameter int unsigned HALT_ON_END = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_DP  = 4'd2,
    S_EXEC_SH  = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_WR   = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_LDI      = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  state_e              state_q, state_d, nxt;
  logic [FLAG_W-1:0]   flag_q, flag_d;
  logic                run_q;
  logic                mem_rdy;
  logic                pc_w, ir_w, reg_w, mem_w, halted_c;
  logic [1:0]          adr_src_c, alu_src_b_c, result_src_c;
  logic [2:0]          reg_src_c;
  logic                imm_src_c, alu_src_a_c;
  logic [ALU_CTRL_W-1:0] alu_ctrl_c;
  logic                strobe_en;
  logic                unused_flags;

`ifdef MC_MEMWAIT_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // Only the Z and C positions are consumed; the other flag bits are kept for completeness.
  assign unused_flags = ^flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flag_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      run_q   <= bus.run;
    end
  end

  always_comb begin
    nxt          = state_q;
    state_d      = state_q;
    flag_d       = flag_q;
    pc_w         = 1'b0;
    ir_w         = 1'b0;
    reg_w        = 1'b0;
    mem_w        = 1'b0;
    halted_c     = 1'b0;
    adr_src_c    = 2'b00;
    reg_src_c    = 3'b000;
    imm_src_c    = 1'b0;
    alu_src_a_c  = 1'b1;
    alu_src_b_c  = 2'b10;
    alu_ctrl_c   = '0;
    result_src_c = 2'b10;

    case (state_q)
      S_FETCH: begin
        ir_w = mem_rdy;
        pc_w = mem_rdy;
        if (mem_rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        case (bus.op)
          2'b00: begin reg_src_c = 3'b100; nxt = S_EXEC_DP; end
          2'b01: begin reg_src_c = 3'b100; nxt = S_EXEC_SH; end
          2'b10: begin
            reg_src_c = (bus.funct[2:1] == 2'b10) ? 3'b110 : 3'b100;
            case (bus.funct[2:1])
              2'b01:   nxt = S_LDI;
              2'b11:   nxt = S_FETCH;
              default: nxt = S_MEM_ADDR;
            endcase
          end
          default: begin
            case (bus.funct)
              3'b001:  reg_src_c = 3'b001;
              3'b010:  reg_src_c = 3'b101;
              default: reg_src_c = 3'b000;
            endcase
            nxt = S_BRANCH;
          end
        endcase
      end
      S_EXEC_DP: begin
        alu_src_a_c = 1'b0;
        alu_src_b_c = 2'b00;
        case (bus.funct)
          3'b010:  alu_ctrl_c = ALU_CTRL_W'(1);
          3'b100:  alu_ctrl_c = ALU_CTRL_W'(2);
          3'b101:  alu_ctrl_c = ALU_CTRL_W'(3);
          3'b110:  alu_ctrl_c = ALU_CTRL_W'(4);
          3'b111:  alu_ctrl_c = ALU_CTRL_W'(5);
          default: alu_ctrl_c = ALU_CTRL_W'(0);
        endcase
        nxt = S_ALU_WB;
      end
      S_EXEC_SH: begin
        alu_src_a_c = 1'b0;
        alu_src_b_c = 2'b00;
        case (bus.funct)
          3'b000:  alu_ctrl_c = ALU_CTRL_W'(6);
          3'b001:  alu_ctrl_c = ALU_CTRL_W'(7);
          3'b010:  alu_ctrl_c = ALU_CTRL_W'(8);
          3'b100:  alu_ctrl_c = ALU_CTRL_W'(9);
          3'b011:  alu_ctrl_c = ALU_CTRL_W'(10);
          default: alu_ctrl_c = ALU_CTRL_W'(0);
        endcase
        nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src_c = 2'b00;
        reg_w        = 1'b1;
        nxt          = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b0;
        alu_src_b_c = 2'b01;
        nxt         = (bus.funct[2:1] == 2'b10) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_WR: begin
        adr_src_c    = 2'b01;
        result_src_c = 2'b00;
        mem_w        = 1'b1;
        if (mem_rdy) nxt = S_FETCH;
      end
      S_MEM_RD: begin
        adr_src_c    = 2'b01;
        result_src_c = 2'b00;
        if (mem_rdy) nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src_c = 2'b01;
        reg_w        = 1'b1;
        nxt          = S_FETCH;
      end
      S_LDI: begin
        imm_src_c    = 1'b1;
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b11;
        reg_w        = 1'b1;
        nxt          = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b0;
        alu_src_b_c = 2'b01;
        nxt         = S_FETCH;
        case (bus.funct)
          3'b000: pc_w = 1'b1;
          3'b001: begin pc_w = 1'b1; reg_w = 1'b1; end
          3'b010: begin pc_w = 1'b1; alu_src_b_c = 2'b00; result_src_c = 2'b11; end
          3'b011: pc_w = flag_q[Z_IDX];
          3'b100: pc_w = ~flag_q[Z_IDX];
          3'b101: pc_w = flag_q[C_IDX];
          3'b110: pc_w = ~flag_q[C_IDX];
          default: if (HALT_ON_END != 0) nxt = S_HALT;
        endcase
      end
      S_HALT: begin
        halted_c = 1'b1;
        // Leave only on a fresh 0->1 of run, so a held run=1 keeps the core parked.
        if (!run_q) nxt = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    if (bus.run) begin
      state_d = nxt;
      if (state_q == S_EXEC_DP || state_q == S_EXEC_SH) flag_d = bus.flags;
    end
  end

  assign strobe_en       = bus.run & rst_n;
  assign bus.pc_write    = pc_w  & strobe_en;
  assign bus.ir_write    = ir_w  & strobe_en;
  assign bus.reg_write   = reg_w & strobe_en;
  assign bus.mem_write   = mem_w & strobe_en;
  assign bus.adr_src     = adr_src_c;
  assign bus.reg_src     = reg_src_c;
  assign bus.imm_src     = imm_src_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.result_src  = result_src_c;
  assign bus.alu_control = alu_ctrl_c;
  assign bus.halted      = halted_c;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm: each task drives one scenario and checks outputs inline.
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.FLAG_W(4), .ALU_CTRL_W(4)) bus ();

  mc_ctrl_fsm #(
    .ALU_CTRL_W(4), .FLAG_W(4), .Z_IDX(2), .C_IDX(1), .HALT_ON_END(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs one data instruction from FETCH; flags are presented in EXEC_DP, then scrambled in ALU_WB.
  task automatic run_dp(input logic [2:0] f, input logic [3:0] fl, input logic [3:0] exp_alu);
    bus.op = 2'b00; bus.funct = f;
    step();
    step();
    bus.flags = fl; #1;
    checks++; if (bus.state !== 4'd2 || bus.alu_control !== exp_alu) begin errors++;
      $display("FAIL dp_exec f=%b: state=%0d alu=%0d expected state=2 alu=%0d", f, bus.state, bus.alu_control, exp_alu); end
    step();
    bus.flags = ~fl; #1;
    checks++; if (bus.state !== 4'd4 || bus.reg_write !== 1'b1 || bus.result_src !== 2'b00) begin errors++;
      $display("FAIL dp_wb: state=%0d reg_write=%b result_src=%b expected 4/1/00", bus.state, bus.reg_write, bus.result_src); end
    step();
  endtask

  task automatic do_branch(input logic [2:0] f, input logic exp_pc, input logic exp_rw);
    bus.op = 2'b11; bus.funct = f;
    step();
    step(); #1;
    checks++; if (bus.state !== 4'd10 || bus.pc_write !== exp_pc || bus.reg_write !== exp_rw) begin errors++;
      $display("FAIL branch f=%b: state=%0d pc_write=%b reg_write=%b expected 10/%b/%b",
               f, bus.state, bus.pc_write, bus.reg_write, exp_pc, exp_rw); end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.state !== 4'd0) begin errors++;
      $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if ({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.halted} !== 5'b0) begin errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.halted}); end
    rst_n = 1'b1; #1;
    checks++; if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin errors++;
      $display("FAIL reset_release_fetch: ir_write=%b pc_write=%b expected 1/1", bus.ir_write, bus.pc_write); end
  endtask

  task automatic test_ldr();
    logic [3:0] exp_st [5];
    exp_st = '{4'd0, 4'd1, 4'd5, 4'd7, 4'd8};
    bus.op = 2'b10; bus.funct = 3'b000; #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.state !== exp_st[i]) begin errors++;
        $display("FAIL ldr_state[%0d]: got %0d expected %0d", i, bus.state, exp_st[i]); end
      checks++; if (bus.reg_write !== (i == 4)) begin errors++;
        $display("FAIL ldr_reg_write[%0d]: got %b expected %b", i, bus.reg_write, (i == 4)); end
      if (i == 4) begin
        checks++; if (bus.result_src !== 2'b01) begin errors++;
          $display("FAIL ldr_result_src: got %b expected 01", bus.result_src); end
      end
      step();
    end
  endtask

  task automatic test_flags_branch();
    run_dp(3'b010, 4'b0100, 4'd1);
    do_branch(3'b011, 1'b1, 1'b0);
    run_dp(3'b010, 4'b0000, 4'd1);
    do_branch(3'b011, 1'b0, 1'b0);
    do_branch(3'b100, 1'b1, 1'b0);
    run_dp(3'b000, 4'b0010, 4'd0);
    do_branch(3'b101, 1'b1, 1'b0);
    do_branch(3'b110, 1'b0, 1'b0);
    do_branch(3'b001, 1'b1, 1'b1);
    do_branch(3'b000, 1'b1, 1'b0);
    run_dp(3'b111, 4'b0000, 4'd5);
  endtask

  task automatic test_reset_mid_ldr();
    run_dp(3'b010, 4'b0100, 4'd1);
    bus.op = 2'b10; bus.funct = 3'b000;
    repeat (3) step();
    checks++; if (bus.state !== 4'd7) begin errors++;
      $display("FAIL midldr_state: got %0d expected 7", bus.state); end
    rst_n = 1'b0; #1;
    checks++; if (bus.state !== 4'd0 || {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0) begin errors++;
      $display("FAIL midldr_abort: state=%0d strobes=%b expected 0/0000", bus.state,
               {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}); end
    repeat (2) step();
    rst_n = 1'b1; #1;
    checks++; if (bus.state !== 4'd0 || bus.ir_write !== 1'b1) begin errors++;
      $display("FAIL midldr_release: state=%0d ir_write=%b expected 0/1", bus.state, bus.ir_write); end
    do_branch(3'b011, 1'b0, 1'b0);
  endtask

  task automatic test_str_pause();
    int mw = 0;
    bus.op = 2'b10; bus.funct = 3'b100;
    bus.run = 1'b0; #1;
    checks++; if (bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin errors++;
      $display("FAIL pause_fetch_strobes: ir=%b pc=%b expected 0/0", bus.ir_write, bus.pc_write); end
    step();
    bus.run = 1'b1; #1;
    checks++; if (bus.state !== 4'd0 || bus.ir_write !== 1'b1) begin errors++;
      $display("FAIL pause_fetch_hold: state=%0d ir=%b expected 0/1", bus.state, bus.ir_write); end
    step();
    checks++; if (bus.state !== 4'd1 || bus.reg_src !== 3'b110) begin errors++;
      $display("FAIL str_decode: state=%0d reg_src=%b expected 1/110", bus.state, bus.reg_src); end
    step();
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.state !== 4'd5) begin errors++;
        $display("FAIL str_pause_hold[%0d]: got %0d expected 5", i, bus.state); end
      mw += int'(bus.mem_write);
      step();
    end
    bus.run = 1'b1; #1;
    checks++; if (bus.state !== 4'd5) begin errors++;
      $display("FAIL str_resume: got %0d expected 5", bus.state); end
    mw += int'(bus.mem_write);
    step();
    checks++; if (bus.state !== 4'd6 || bus.adr_src !== 2'b01) begin errors++;
      $display("FAIL str_memwr: state=%0d adr_src=%b expected 6/01", bus.state, bus.adr_src); end
    mw += int'(bus.mem_write);
    step();
    mw += int'(bus.mem_write);
    checks++; if (bus.state !== 4'd0 || mw != 1) begin errors++;
      $display("FAIL str_mem_write_count: state=%0d count=%0d expected 0/1", bus.state, mw); end
  endtask

  task automatic test_ldi_shift_nop();
    bus.op = 2'b10; bus.funct = 3'b010;
    step(); step();
    checks++; if (bus.state !== 4'd9 || bus.reg_write !== 1'b1 || bus.result_src !== 2'b11 || bus.imm_src !== 1'b1) begin errors++;
      $display("FAIL ldi: state=%0d rw=%b rs=%b imm=%b expected 9/1/11/1", bus.state, bus.reg_write, bus.result_src, bus.imm_src); end
    step();
    checks++; if (bus.state !== 4'd0) begin errors++;
      $display("FAIL ldi_latency: got %0d expected 0", bus.state); end
    bus.op = 2'b01; bus.funct = 3'b100;
    step(); step();
    checks++; if (bus.state !== 4'd3 || bus.alu_control !== 4'd9) begin errors++;
      $display("FAIL shift_lsr: state=%0d alu=%0d expected 3/9", bus.state, bus.alu_control); end
    step(); step();
    bus.op = 2'b01; bus.funct = 3'b011;
    step(); step();
    checks++; if (bus.state !== 4'd3 || bus.alu_control !== 4'd10) begin errors++;
      $display("FAIL shift_asr: state=%0d alu=%0d expected 3/10", bus.state, bus.alu_control); end
    step(); step();
    bus.op = 2'b10; bus.funct = 3'b110;
    step(); step();
    checks++; if (bus.state !== 4'd0) begin errors++;
      $display("FAIL mem_nop: got %0d expected 0", bus.state); end
  endtask

  task automatic test_halt();
    bus.op = 2'b11; bus.funct = 3'b111;
    step(); step();
    checks++; if (bus.state !== 4'd10 || bus.pc_write !== 1'b0) begin errors++;
      $display("FAIL end_branch: state=%0d pc_write=%b expected 10/0", bus.state, bus.pc_write); end
    step();
    repeat (3) step();
    checks++; if (bus.state !== 4'd11 || bus.halted !== 1'b1 ||
                  {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0) begin errors++;
      $display("FAIL halt_sticky: state=%0d halted=%b expected 11/1", bus.state, bus.halted); end
    bus.run = 1'b0;
    step();
    bus.run = 1'b1; #1;
    checks++; if (bus.state !== 4'd11) begin errors++;
      $display("FAIL halt_edge_cycle: got %0d expected 11", bus.state); end
    step();
    checks++; if (bus.state !== 4'd0 || bus.halted !== 1'b0) begin errors++;
      $display("FAIL halt_exit: state=%0d halted=%b expected 0/0", bus.state, bus.halted); end
  endtask

`ifdef MC_MEMWAIT_EN
  task automatic test_memwait();
    bus.op = 2'b10; bus.funct = 3'b110;
    bus.mem_ready = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.state !== 4'd0 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin errors++;
        $display("FAIL memwait_hold[%0d]: state=%0d ir=%b pc=%b expected 0/0/0", i, bus.state, bus.ir_write, bus.pc_write); end
      step();
    end
    bus.mem_ready = 1'b1; #1;
    checks++; if (bus.state !== 4'd0 || bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin errors++;
      $display("FAIL memwait_ready: state=%0d ir=%b pc=%b expected 0/1/1", bus.state, bus.ir_write, bus.pc_write); end
    step();
    checks++; if (bus.state !== 4'd1) begin errors++;
      $display("FAIL memwait_decode: got %0d expected 1", bus.state); end
    step();
  endtask
`endif

  initial begin
    bus.run   = 1'b1;
    bus.op    = 2'b00;
    bus.funct = 3'b000;
    bus.flags = 4'b0000;
`ifdef MC_MEMWAIT_EN
    bus.mem_ready = 1'b1;
`endif
    test_reset();
    test_ldr();
    test_flags_branch();
    test_reset_mid_ldr();
    test_str_pause();
    test_ldi_shift_nop();
    test_halt();
`ifdef MC_MEMWAIT_EN
    test_memwait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
